fifo_push_packer: RTL

- Upstream feeder for the basic FIFO's push port.
- Accepts narrow beats on a valid/ready stream and packs RATIO consecutive beats into one WIDTH-bit word.
- Drives pu_en/pu_data only when the FIFO reports not-full and ready.
- Flushes a partial word early on in_last, then pads the unused lanes.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_push_packer.sv | 108 ++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the basic FIFO and its push-side packer.
package fifo_pkg;

  typedef enum logic {FILL, HOLD} packer_state_t;

  localparam int FIFO_WIDTH = 10;
  localparam int FIFO_DEPTH = 32;

  // Widest word pack_lane can handle; callers cast to their own width.
  localparam int PACK_MAX = 64;

  // Return word with beat written into lane (lane_w bits per lane).
  function automatic logic [PACK_MAX-1:0] pack_lane(
    input logic [PACK_MAX-1:0] word,
    input int                  lane,
    input logic [PACK_MAX-1:0] beat,
    input int                  lane_w
  );
    logic [PACK_MAX-1:0] mask;
    mask = ((PACK_MAX'(1) << lane_w) - PACK_MAX'(1)) << (lane * lane_w);
    return (word & ~mask) | ((beat << (lane * lane_w)) & mask);
  endfunction

endpackage

// File: rtl/fifo_push_packer.sv
// Packs RATIO narrow beats into one FIFO word and pushes it when the FIFO
// has room. in_last closes a word early; unused upper lanes are padded.
// Optional: FIFO_PUSH_PACKER_REPLICATE_PAD_EN pads with copies of the final
// beat instead of zeros.
module fifo_push_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH = FIFO_WIDTH / 2,
  parameter int RATIO    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_last,
  input  logic                      fifo_ready,
  input  logic                      fifo_full,
  output logic                      pu_en,
  output logic [IN_WIDTH*RATIO-1:0] pu_data,
  output logic [15:0]               words_pushed
);

  localparam int WIDTH    = IN_WIDTH * RATIO;
  localparam int LG_RATIO = $clog2(RATIO);
  localparam logic [LG_RATIO-1:0] LAST_LANE = LG_RATIO'(RATIO - 1);

  packer_state_t       state, state_nxt;
  logic [LG_RATIO-1:0] lane;
  logic [WIDTH-1:0]    word;

  logic                acc;
  logic                close;
  logic [LG_RATIO-1:0] wr_lane;
  logic [WIDTH-1:0]    base_word;
  logic [WIDTH-1:0]    written;
  logic [WIDTH-1:0]    padded;
  logic [IN_WIDTH-1:0] pad_beat;

  // Handshake and push strobe; a word pushing this cycle frees room for a beat.
  always_comb begin
    in_ready = fifo_ready && ((state == FILL) || !fifo_full);
    pu_en    = (state == HOLD) && fifo_ready && !fifo_full;
    acc      = in_valid && in_ready;
    pu_data  = word;
  end

`ifdef FIFO_PUSH_PACKER_REPLICATE_PAD_EN
  assign pad_beat = in_data;
`else
  assign pad_beat = '0;
`endif

  // Word being built by an accepted beat. In HOLD an accept always coincides
  // with a push, so the new word starts fresh at lane 0.
  always_comb begin
    base_word = (state == HOLD) ? '0 : word;
    wr_lane   = (state == HOLD) ? '0 : lane;
    close     = in_last || (wr_lane == LAST_LANE);
    written   = WIDTH'(pack_lane(PACK_MAX'(base_word), int'(wr_lane),
                                 PACK_MAX'(in_data), IN_WIDTH));
    padded    = written;
    for (int j = 1; j < RATIO; j++) begin
      if (j > int'(wr_lane))
        padded = WIDTH'(pack_lane(PACK_MAX'(padded), j,
                                  PACK_MAX'(pad_beat), IN_WIDTH));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next state: close on the last lane or in_last; leave HOLD once pushed.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (acc && close) state_nxt = HOLD;
      HOLD: begin
        if (pu_en) state_nxt = (acc && close) ? HOLD : FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Lane write, padding and lane pointer; a push without a new beat clears the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      lane <= '0;
    end else if (acc) begin
      word <= close ? padded : written;
      lane <= close ? '0 : wr_lane + LG_RATIO'(1);
    end else if (pu_en) begin
      word <= '0;
      lane <= '0;
    end
  end

  // Pushed-word counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)        words_pushed <= '0;
    else if (pu_en) words_pushed <= words_pushed + 16'd1;
  end

endmodule
